// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: sequencer states and grant ids.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic GNT_CPU  = 1'b0;
    localparam logic GNT_HOST = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_lock_picker.sv
// Combinational winner select: round-robin between CPU and host, with a
// bounded host lock that lets the host keep the port for a burst.
module rr_lock_picker
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             cpu_req,
    input  logic             host_req,
    input  logic             host_lock,
    input  logic             last_grant,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             any_req,
    output logic             winner
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    always_comb begin
        any_req = cpu_req | host_req;
        winner  = GNT_CPU;
        if (host_req && !cpu_req) begin
            winner = GNT_HOST;
        end else if (host_req && cpu_req) begin
            if ((last_grant == GNT_HOST) && host_lock && (burst_cnt < MAX_CNT)) begin
                winner = GNT_HOST;
            end else begin
                winner = ~last_grant;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU load/store path and a
// host port through an IDLE -> ACCESS -> DONE sequencer.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              RESET_N,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              winner_q;
    logic              lat_we_q;
    logic [ADDR_W-1:0] lat_addr_q;
    logic [DATA_W-1:0] lat_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] host_rdata_q;
    logic              any_req;
    logic              pick;

    rr_lock_picker #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_picker (
        .cpu_req    (cpu_req),
        .host_req   (host_req),
        .host_lock  (host_lock),
        .last_grant (last_grant_q),
        .burst_cnt  (burst_cnt_q),
        .any_req    (any_req),
        .winner     (pick)
    );

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (any_req) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Burst accounting only moves in IDLE, where arbitration happens.
    always_comb begin
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        if (state_q == ST_IDLE) begin
            if (any_req) begin
                last_grant_d = pick;
                if ((pick == GNT_HOST) && host_lock) begin
                    if (last_grant_q == GNT_HOST) begin
                        burst_cnt_d = (burst_cnt_q == MAX_CNT) ? MAX_CNT : burst_cnt_q + 1'b1;
                    end else begin
                        burst_cnt_d = CNT_W'(1);
                    end
                end else begin
                    burst_cnt_d = '0;
                end
            end else if (!host_lock) begin
                burst_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            last_grant_q <= GNT_HOST;
            burst_cnt_q  <= '0;
            winner_q     <= GNT_CPU;
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            if ((state_q == ST_IDLE) && any_req) begin
                winner_q    <= pick;
                lat_we_q    <= (pick == GNT_HOST) ? host_we    : cpu_we;
                lat_addr_q  <= (pick == GNT_HOST) ? host_addr  : cpu_addr;
                lat_wdata_q <= (pick == GNT_HOST) ? host_wdata : cpu_wdata;
            end
            if ((state_q == ST_ACCESS) && !lat_we_q) begin
                if (winner_q == GNT_HOST) begin
                    host_rdata_q <= mem_rdata;
                end else begin
                    cpu_rdata_q <= mem_rdata;
                end
            end
        end
    end

    // Gating the strobe with RESET_N keeps a reset in ACCESS from committing the write.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        mem_we    = (state_q == ST_ACCESS) && lat_we_q && RESET_N;
        cpu_ack   = (state_q == ST_DONE) && (winner_q == GNT_CPU);
        host_ack  = (state_q == ST_DONE) && (winner_q == GNT_HOST);
        cpu_stall = cpu_req && !cpu_ack;
    end

    assign mem_addr   = lat_addr_q;
    assign mem_wdata  = lat_wdata_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign host_rdata = host_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data-memory port of the unpipelined beta core between the CPU load/store path and a host port (test/loader, e.g. preloading fingerprint data or reading results). Each access runs through a three-state sequencer with registered grant, address and read data. Round-robin fairness is enforced, and the host can hold a bounded lock for bursts. The block sits between beta's LD/ST datapath and the dm instance; the CPU stalls while it waits.

Parameters:
DATA_W, 32, data word width
ADDR_W, 10, word-address width into data memory
MAX_BURST, 4, max consecutive host grants under host_lock while CPU waits (>=1)

Ports:
clk  in  1  system clock, rising edge
RESET_N  in  1  synchronous, active-low reset
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data; valid while cpu_ack, held afterwards
cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
host_req  in  1  host access request; held until host_ack
host_we  in  1  1=write
host_addr  in  ADDR_W  host word address
host_wdata  in  DATA_W  host write data
host_lock  in  1  request back-to-back host grants
host_ack  out  1  one-cycle completion pulse
host_rdata  out  DATA_W  read data; valid while host_ack, held afterwards
mem_addr  out  ADDR_W  to data memory
mem_wdata  out  DATA_W  to data memory
mem_we  out  1  write strobe; memory writes on clk edge while high
mem_rdata  in  DATA_W  combinational read data from memory
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, ACCESS, DONE. Reset (RESET_N=0 at an edge) forces IDLE. All outputs go to 0, last_grant=HOST (CPU wins the first tie), burst_cnt=0.
- IDLE: if no req, stay. Otherwise pick a winner, latch its we/addr/wdata plus the winner id into registers, and go to ACCESS.
- ACCESS (one cycle): mem_addr/mem_wdata driven from latched registers. mem_we = latched we (registered, high only in ACCESS). On the edge, the memory commits any write and mem_rdata is captured into the winner's rdata register (reads only). Go to DONE.
- DONE (one cycle): winner's ack=1, other ack=0. Go to IDLE.
- Latency: req sampled at edge N, ack high in cycle N+2. Max throughput is 1 access per 3 cycles. Requester must drop or change req in the cycle after ack; a req still high in IDLE is treated as a new request.
- Arbitration (IDLE only):
  - Single requester wins.
  - Both requesting: host wins if last_grant=HOST & host_lock & burst_cnt<MAX_BURST. Otherwise the requester not equal to last_grant wins.
- burst_cnt:
  - Host grant with host_lock=1 and last_grant=HOST: increment, saturating at MAX_BURST.
  - Any other host grant: set to 1.
  - CPU grant, or host_lock=0 in IDLE: clear.
- host_lock has no effect when cpu_req=0; the host then simply wins every slot.
- Non-winner's ack stays 0; its request waits with no starvation (worst-case CPU wait = MAX_BURST host accesses).
- Requester inputs are ignored outside IDLE; changes after grant do not affect the in-flight access.
- Reset mid-operation: an access in ACCESS is aborted if reset is sampled before its write edge. No ack is issued; the rdata registers clear to 0.
- mem_addr/mem_wdata outside ACCESS keep their last latched value; only mem_we matters.

Decomposition:
- Shared package dmem_arb_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), grant id constants GNT_CPU=1'b0, GNT_HOST=1'b1.
- One natural sub-module, rr_lock_picker: combinational winner select from cpu_req, host_req, host_lock, last_grant, burst_cnt, MAX_BURST.
- FSM, latches and counters stay in dmem_arbiter.

Test Plan:
- Reset: RESET_N=0 for 2 edges with cpu_req=1 -> busy=0, mem_we=0, acks=0. After release, the first ack arrives 2 cycles after the first sampled req.
- CPU write then read: write addr 5, data 50; read addr 5 -> mem_we high exactly 1 cycle, cpu_ack at N+2, cpu_rdata=50, cpu_stall high 2 cycles per access.
- Simultaneous req after reset, host_lock=0 -> CPU granted first, host next; repeated ties alternate C,H,C,H.
- host_lock=1, MAX_BURST=4, both requesting continuously -> grant order H×4, C, H×4, C (after an initial host grant); CPU never waits >4 host accesses.
- Host preloads addr 0..9 with 10*i, then the CPU reads addr 9 -> cpu_rdata=90, host_rdata unchanged.
- RESET_N=0 sampled during an ACCESS write to addr 3 (data 7) -> no ack, memory[3] unchanged, state IDLE, rdata=0.
